// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode, funct, ALU-code constants and per-state control decode.
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_BEQEX = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:            begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:           c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:            c.iord = 1'b1;
      S_MEMWB:            begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:            begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX:          begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWB:          begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_ADDIWB:           c.regwrite = 1'b1;
      S_BEQEX:            begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_JEX:              begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:            c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields and zero flag in, datapath controls out.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;
  modport master (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, alucontrol, illegal, state
  );
  modport slave (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/alu_dec.sv
// alu_dec: maps aluop and R-type funct to the ALU function code.
module alu_dec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop != ALUOP_FUNCT ? ALU_ADD :
                 funct == F_SUB       ? ALU_SUB :
                 funct == F_AND       ? ALU_AND :
                 funct == F_OR        ? ALU_OR  :
                 funct == F_SLT       ? ALU_SLT : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/writeback for a multicycle MIPS.
module multicycle_ctrl
  import mips_pkg::*;
(
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.slave  bus
);
  state_t     state_q, state_d;
  ctrl_t      ctl_q, ctl_d;
  logic       op_ok;
  logic [2:0] alucontrol;
  always_comb begin
    op_ok = bus.op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                           bus.op == OP_RTYPE ? S_RTYPEEX :
                           bus.op == OP_BEQ   ? S_BEQEX   :
                           bus.op == OP_ADDI  ? S_ADDIEX  :
                           bus.op == OP_J     ? S_JEX     : S_FETCH;
      S_MEMADR:  state_d = bus.op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    // Controls are registered alongside the state so they stay a pure function of it.
    ctl_d = ctrl_of(state_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctl_q   <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end
  alu_dec u_alu_dec (.aluop(ctl_q.aluop), .funct(bus.funct), .alucontrol(alucontrol));
  assign bus.pcen       = ctl_q.pcwrite | (ctl_q.branch & bus.zero);
  assign bus.memwrite   = ctl_q.memwrite;
  assign bus.irwrite    = ctl_q.irwrite;
  assign bus.regwrite   = ctl_q.regwrite;
  assign bus.iord       = ctl_q.iord;
  assign bus.memtoreg   = ctl_q.memtoreg;
  assign bus.regdst     = ctl_q.regdst;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.pcsrc      = ctl_q.pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = state_q == S_DECODE && !op_ok;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus queues hand-computed per-cycle vectors, a monitor checks them.
module tb_multicycle_ctrl;
  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] S = 3'b110;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t m_e;
  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [19:0] act();
    return {bus.state, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
            bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.alucontrol, bus.illegal};
  endfunction
  // Hand-written control bits per state: memwrite irwrite regwrite iord memtoreg regdst alusrca alusrcb pcsrc
  function automatic logic [19:0] ev(logic [3:0] s, logic [2:0] alu, logic pcen, logic ill);
    logic [10:0] c;
    case (s)
      4'd0:        c = 11'b0_1_0_0_0_0_0_01_00;
      4'd1:        c = 11'b0_0_0_0_0_0_0_11_00;
      4'd2, 4'd9:  c = 11'b0_0_0_0_0_0_1_10_00;
      4'd3:        c = 11'b0_0_0_1_0_0_0_00_00;
      4'd4:        c = 11'b0_0_1_0_1_0_0_00_00;
      4'd5:        c = 11'b1_0_0_1_0_0_0_00_00;
      4'd6:        c = 11'b0_0_0_0_0_0_1_00_00;
      4'd7:        c = 11'b0_0_1_0_0_1_0_00_00;
      4'd8:        c = 11'b0_0_0_0_0_0_1_00_01;
      4'd10:       c = 11'b0_0_1_0_0_0_0_00_00;
      4'd11:       c = 11'b0_0_0_0_0_0_0_00_10;
      default:     c = 11'b0;
    endcase
    return {s, pcen, c, alu, ill};
  endfunction
  task automatic push(string name, logic [19:0] v);
    exp_t e;
    e.name = name;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic ins(logic [5:0] op, logic [5:0] funct, logic zero);
    bus.op = op;
    bus.funct = funct;
    bus.zero = zero;
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk or posedge chk);
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_vec++;
      if (act() !== m_e.v) begin
        n_bad++;
        $display("FAIL %s: got %05h expected %05h", m_e.name, act(), m_e.v);
      end
    end
  end
  initial begin
    ins(6'b000000, 6'b000000, 1'b0);
    push("reset_fetch", ev(0, A, 1, 0));
    cyc(2);
    rst = 1'b0;
    ins(6'b100011, 6'b000000, 1'b0);
    push("lw_fetch", ev(0, A, 1, 0));
    push("lw_decode", ev(1, A, 0, 0));
    push("lw_memadr", ev(2, A, 0, 0));
    push("lw_memrd", ev(3, A, 0, 0));
    push("lw_memwb", ev(4, A, 0, 0));
    cyc(5);
    ins(6'b000000, 6'b101010, 1'b0);
    push("slt_fetch", ev(0, A, 1, 0));
    push("slt_decode", ev(1, A, 0, 0));
    push("slt_ex", ev(6, 3'b111, 0, 0));
    push("slt_wb", ev(7, A, 0, 0));
    cyc(4);
    ins(6'b000000, 6'b100100, 1'b0);
    push("and_fetch", ev(0, A, 1, 0));
    push("and_decode", ev(1, A, 0, 0));
    push("and_ex", ev(6, 3'b000, 0, 0));
    push("and_wb", ev(7, A, 0, 0));
    cyc(4);
    ins(6'b000000, 6'b100101, 1'b0);
    push("or_fetch", ev(0, A, 1, 0));
    push("or_decode", ev(1, A, 0, 0));
    push("or_ex", ev(6, 3'b001, 0, 0));
    push("or_wb", ev(7, A, 0, 0));
    cyc(4);
    ins(6'b000000, 6'b100010, 1'b0);
    push("sub_fetch", ev(0, A, 1, 0));
    push("sub_decode", ev(1, A, 0, 0));
    push("sub_ex", ev(6, S, 0, 0));
    push("sub_wb", ev(7, A, 0, 0));
    cyc(4);
    ins(6'b000000, 6'b111111, 1'b0);
    push("badfunct_fetch", ev(0, A, 1, 0));
    push("badfunct_decode", ev(1, A, 0, 0));
    push("badfunct_ex", ev(6, A, 0, 0));
    push("badfunct_wb", ev(7, A, 0, 0));
    cyc(4);
    ins(6'b000100, 6'b100101, 1'b1);
    push("beq_t_fetch", ev(0, A, 1, 0));
    push("beq_t_decode", ev(1, A, 0, 0));
    push("beq_t_ex", ev(8, S, 1, 0));
    cyc(3);
    ins(6'b000100, 6'b100101, 1'b0);
    push("beq_nt_fetch", ev(0, A, 1, 0));
    push("beq_nt_decode", ev(1, A, 0, 0));
    push("beq_nt_ex", ev(8, S, 0, 0));
    cyc(3);
    ins(6'b101011, 6'b000000, 1'b1);
    push("sw_fetch", ev(0, A, 1, 0));
    push("sw_decode", ev(1, A, 0, 0));
    push("sw_memadr", ev(2, A, 0, 0));
    push("sw_memwr", ev(5, A, 0, 0));
    cyc(4);
    ins(6'b001000, 6'b000000, 1'b0);
    push("addi_fetch", ev(0, A, 1, 0));
    push("addi_decode", ev(1, A, 0, 0));
    push("addi_ex", ev(9, A, 0, 0));
    push("addi_wb", ev(10, A, 0, 0));
    cyc(4);
    ins(6'b000010, 6'b000000, 1'b0);
    push("j_fetch", ev(0, A, 1, 0));
    push("j_decode", ev(1, A, 0, 0));
    push("j_ex", ev(11, A, 1, 0));
    cyc(3);
    ins(6'b111111, 6'b000000, 1'b0);
    push("ill_fetch", ev(0, A, 1, 0));
    push("ill_decode", ev(1, A, 0, 1));
    cyc(2);
    ins(6'b000001, 6'b000000, 1'b1);
    push("ill2_fetch", ev(0, A, 1, 0));
    push("ill2_decode", ev(1, A, 0, 1));
    cyc(2);
    ins(6'b100011, 6'b000000, 1'b0);
    push("rstlw_fetch", ev(0, A, 1, 0));
    push("rstlw_decode", ev(1, A, 0, 0));
    push("rstlw_memadr", ev(2, A, 0, 0));
    push("rstlw_memrd", ev(3, A, 0, 0));
    cyc(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("rst_async", ev(0, A, 1, 0));
    chk = 1'b1;
    #1;
    chk = 1'b0;
    push("rst_held", ev(0, A, 1, 0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    ins(6'b000010, 6'b000000, 1'b0);
    push("post_rst_decode", ev(1, A, 0, 0));
    push("post_rst_jex", ev(11, A, 1, 0));
    cyc(3);
    push("final_fetch", ev(0, A, 1, 0));
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath mux selects and write enables, and it drives the 3-bit ALU function code `f` into the ALU directly downstream. It supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

## Interface
- No parameters. Opcode, funct, state and ALU-code values are fixed constants from the shared package.
- `clk` in 1: single clock. All state changes occur on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: instr[31:26], taken from the instruction register.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag for the current cycle.
- `pcen` out 1: PC write enable.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: instruction register load enable.
- `regwrite` out 1: register file write enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: writeback data select. 0 = ALUOut, 1 = MDR.
- `regdst` out 1: destination register select. 0 = rt, 1 = rd.
- `alusrca` out 1: ALU a select. 0 = PC, 1 = reg A.
- `alusrcb` out 2: ALU b select. 00 = reg B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `pcsrc` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 3: ALU function code. Connects to ALU `f`.
- `illegal` out 1: high for the single DECODE cycle when `op` is unsupported.
- `state` out 4: current state, for debug and for the bench.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
  - Encodings 12–15 are unreachable. If reached, the next state is FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 001000 → ADDIEX
    - 000010 → JEX
    - any other op → FETCH, with `illegal`=1
  - MEMADR: lw → MEMRD, sw → MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX → FETCH.
- Outputs are a pure function of `state`, except `pcen` and `alucontrol`. Any signal not listed for a state is 0.
  - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
- `pcen` = pcwrite | (branch & zero). It is combinational on `zero` within BEQEX.
- ALU decode (`aluop` is internal, 2 bits):
  - aluop 00 → 010 (add)
  - aluop 01 → 110 (sub)
  - aluop 10 decodes `funct`:
    - 100000 → 010, 100010 → 110
    - 100100 → 000, 100101 → 001
    - 101010 → 111
    - any other funct → 010
  - aluop 11 → 010.

## Timing
- Reset: while `rst`=1, state = FETCH immediately (asynchronous). Outputs then show the FETCH decode: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0.
  - The datapath registers are held in reset by the same `rst`, so these enables are harmless.
- Reset mid-instruction: the instruction is abandoned and no further write enables are asserted. After deassertion, the first rising edge moves FETCH→DECODE.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each write enable is high for exactly one cycle per instruction. pcen is the exception: twice for j (FETCH and JEX), and twice for beq when taken.
- `illegal` and `alucontrol` are combinational. Sample them before the rising edge.

## Structure
- Shared package/header `mips_pkg`:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU codes: ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111
  - aluop codes
- The ALU module imports the same ALU codes.
- One sub-module, `alu_dec`, is combinational: (aluop, funct) → alucontrol. The FSM lives in `multicycle_ctrl`.

## Test plan
- rst=1 mid-MEMRD, then released → state=0 asynchronously, irwrite=1, pcen=1. The next edge gives state=1.
- op=100011 → states 0,1,2,3,4,0. In state 4, regwrite=1 and memtoreg=1. In state 2, alucontrol=010 and alusrcb=10.
- op=000000, funct=101010 → in RTYPEEX, alucontrol=111. In RTYPEWB, regdst=1 and regwrite=1. Back to FETCH after 4 cycles.
- op=000100 → in BEQEX, alucontrol=110. With zero=1, pcen=1 and pcsrc=01. With zero=0, pcen=0. The next state is FETCH either way.
- op=101011 → memwrite=1 only in state 5, with iord=1. op=000010 → JEX with pcsrc=10 and pcen=1.
- op=111111 → illegal=1 for one cycle in DECODE, then FETCH, with no regwrite or memwrite.
